// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding a downstream sequence detector.
// Words pass through a 2-entry FIFO and are shifted out one bit per clock, with no gap between queued words.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_inc;
  logic [WIDTH-1:0] shreg_q;
  logic             x_q, x_valid_q, last_q;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  function automatic logic tap(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // Ready is decoded from the registered count alone, so upstream sees no combinational path.
  assign in_ready    = (count_q != 2'd2);
  assign push        = in_valid && in_ready;
  assign pop         = (count_q != 2'd0) && ((state_q == IDLE) || (bit_cnt_q == LAST_IDX));
  assign head        = mem_q[rd_ptr_q];
  assign bit_cnt_inc = bit_cnt_q + CNT_ONE;

  always_comb begin
    // NOTE: assign a default before the case so that no path leaves count_d unassigned and infers a latch.
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: use non-blocking assignments in clocked blocks so that every register samples values from before the edge.
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset because count_q and the pointers already mark every entry invalid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // A pop takes priority: it starts a word from IDLE or chains the next word without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      last_q    <= 1'b0;
    end else if (pop) begin
      state_q   <= SHIFT;
      bit_cnt_q <= '0;
      shreg_q   <= advance(head);
      x_q       <= tap(head);
      x_valid_q <= 1'b1;
      last_q    <= 1'b0;
    end else if ((state_q == SHIFT) && (bit_cnt_q != LAST_IDX)) begin
      bit_cnt_q <= bit_cnt_inc;
      shreg_q   <= advance(shreg_q);
      x_q       <= tap(shreg_q);
      x_valid_q <= 1'b1;
      last_q    <= (bit_cnt_inc == LAST_IDX);
    end else begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      last_q    <= 1'b0;
    end
  end

  assign x        = x_q;
  assign x_valid  = x_valid_q;
  assign last_bit = last_q;
  assign busy     = (state_q == SHIFT) || (count_q != 2'd0);

endmodule
